// File: rtl/persp_attr_interp_mc.sv
`default_nettype none
// ============================================================================
//  Module      : persp_attr_interp_mc
//  Description : Multi-cycle perspective-correct attribute interpolator.
//                Evaluates A/w and 1/w planes at a pixel, forms 1/(1/w) with
//                a bit-serial restoring divider, then scales each channel.
//  Revision    : 1.0  initial release
// ============================================================================
module persp_attr_interp_mc #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int NCH  = 4,
    parameter int TAGW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [TAGW-1:0]     tag_in,
    input  logic [NCH*W-1:0]    base_a,
    input  logic [NCH*W-1:0]    dadx,
    input  logic [NCH*W-1:0]    dady,
    input  logic [W-1:0]        base_w,
    input  logic [W-1:0]        dwdx,
    input  logic [W-1:0]        dwdy,
    input  logic [W-1:0]        px,
    input  logic [W-1:0]        py,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [NCH*W-1:0]    attr_out,
    output logic [TAGW-1:0]     tag_out,
    output logic                err
);

    localparam int CNTW = $clog2(W + 1);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [W-1:0]          C_WMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]          C_WMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0] C_SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] C_SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    // Dividend 2^(2*FRAC); any den at or below C_HI would give a quotient >= 2^(W-1).
    localparam logic [2*W-1:0]        C_DVD  = {{(2*W-1){1'b0}}, 1'b1} << (2 * FRAC);
    localparam logic [2*W-1:0]        C_HI   = C_DVD >> (W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EVAL = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [W-1:0] f_sat(input logic signed [2*W-1:0] v);
        if (v > C_SMAX)
            return C_WMAX;
        else if (v < C_SMIN)
            return C_WMIN;
        else
            return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] f_plane(input logic [W-1:0] a, input logic [W-1:0] gx,
                                             input logic [W-1:0] gy, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic signed [2*W-1:0] acc;
        acc = $signed({{W{gx[W-1]}}, gx}) * $signed({{W{x[W-1]}}, x})
            + $signed({{W{gy[W-1]}}, gy}) * $signed({{W{y[W-1]}}, y})
            + ($signed({{W{a[W-1]}}, a}) <<< FRAC);
        return f_sat(acc >>> FRAC);
    endfunction

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [NCH*W-1:0]    r_base_a;
    logic [NCH*W-1:0]    r_dadx;
    logic [NCH*W-1:0]    r_dady;
    logic [W-1:0]        r_base_w;
    logic [W-1:0]        r_dwdx;
    logic [W-1:0]        r_dwdy;
    logic [W-1:0]        r_px;
    logic [W-1:0]        r_py;
    logic [NCH*W-1:0]    r_num;
    logic [W-1:0]        r_den;
    logic                r_fault;
    logic [W-1:0]        r_rem;
    logic [W-1:0]        r_dvd;
    logic [W-1:0]        r_recip;
    logic [CNTW-1:0]     r_cnt;
    logic [IDXW-1:0]     r_idx;

    logic [NCH*W-1:0]    w_num;
    logic [W-1:0]        w_den;
    logic                w_fault;
    logic [W:0]          w_trial;
    logic                w_ge;
    logic [W-1:0]        w_mul_a;
    logic signed [2*W-1:0] w_prod;
    logic [W-1:0]        w_mres;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_num[i*W +: W] = f_plane(r_base_a[i*W +: W], r_dadx[i*W +: W],
                                         r_dady[i*W +: W], r_px, r_py);
    end

    assign w_den   = f_plane(r_base_w, r_dwdx, r_dwdy, r_px, r_py);
    assign w_fault = w_den[W-1] || (w_den == '0) || ({{W{1'b0}}, w_den} <= C_HI);

    // Restoring step: quotient bits are shifted straight into r_recip.
    assign w_trial = {r_rem, r_dvd[W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_den});

    assign w_mul_a = r_num[r_idx*W +: W];
    assign w_prod  = $signed({{W{w_mul_a[W-1]}}, w_mul_a}) * $signed({{W{1'b0}}, r_recip});
    assign w_mres  = f_sat(w_prod >>> FRAC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            attr_out  <= '0;
            tag_out   <= '0;
            err       <= 1'b0;
            r_mode    <= '0;
            r_base_a  <= '0;
            r_dadx    <= '0;
            r_dady    <= '0;
            r_base_w  <= '0;
            r_dwdx    <= '0;
            r_dwdy    <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_num     <= '0;
            r_den     <= '0;
            r_fault   <= 1'b0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_recip   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode   <= mode;
                        tag_out  <= tag_in;
                        r_base_a <= base_a;
                        r_dadx   <= dadx;
                        r_dady   <= dady;
                        r_base_w <= base_w;
                        r_dwdx   <= dwdx;
                        r_dwdy   <= dwdy;
                        r_px     <= px;
                        r_py     <= py;
                        err      <= 1'b0;
                        in_ready <= 1'b0;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_num <= w_num;
                    case (r_mode)
                        2'd0: begin
                            r_den   <= w_den;
                            r_fault <= w_fault;
                            r_rem   <= C_DVD[2*W-1:W];
                            r_dvd   <= C_DVD[W-1:0];
                            r_recip <= '0;
                            r_cnt   <= '0;
                            r_state <= S_DIV;
                        end
                        2'd2: begin
                            attr_out  <= r_base_a;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                        default: begin
                            attr_out  <= w_num;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    endcase
                end
                S_DIV: begin
                    r_rem   <= w_ge ? (w_trial[W-1:0] - r_den) : w_trial[W-1:0];
                    r_dvd   <= {r_dvd[W-2:0], 1'b0};
                    r_recip <= {r_recip[W-2:0], w_ge};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(W - 1)) begin
                        err     <= r_fault;
                        r_idx   <= '0;
                        r_state <= S_MUL;
                        if (r_fault)
                            r_recip <= C_WMAX;
                    end
                end
                S_MUL: begin
                    attr_out[r_idx*W +: W] <= w_mres;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDXW'(NCH - 1)) begin
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_persp_attr_interp_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_persp_attr_interp_mc
//  Description : Scoreboard bench for persp_attr_interp_mc (W=32, FRAC=16, NCH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_persp_attr_interp_mc;

    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int NCH  = 4;
    localparam int TAGW = 8;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [TAGW-1:0]    tag_in;
    logic [NCH*W-1:0]   base_a;
    logic [NCH*W-1:0]   dadx;
    logic [NCH*W-1:0]   dady;
    logic [W-1:0]       base_w;
    logic [W-1:0]       dwdx;
    logic [W-1:0]       dwdy;
    logic [W-1:0]       px;
    logic [W-1:0]       py;
    logic               out_ready;
    logic               out_valid;
    logic [NCH*W-1:0]   attr_out;
    logic [TAGW-1:0]    tag_out;
    logic               err;

    persp_attr_interp_mc #(.W(W), .FRAC(FRAC), .NCH(NCH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .tag_in(tag_in), .base_a(base_a), .dadx(dadx), .dady(dady),
        .base_w(base_w), .dwdx(dwdx), .dwdy(dwdy), .px(px), .py(py),
        .out_ready(out_ready), .out_valid(out_valid), .attr_out(attr_out),
        .tag_out(tag_out), .err(err)
    );

    typedef struct packed {
        logic [NCH*W-1:0] attr;
        logic [TAGW-1:0]  tag;
        logic             err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: a result leaves the DUT whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got tag %h, expected no output", tag_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("attr_tag%h", e.tag), attr_out, e.attr);
                chk($sformatf("tag_tag%h", e.tag), tag_out, e.tag);
                chk($sformatf("err_tag%h", e.tag), err, e.err);
            end
        end
    end

    task automatic drive(input logic [1:0] m, input logic [7:0] tg, input logic [127:0] ba,
                         input logic [127:0] dx, input logic [127:0] dy, input logic [31:0] bw,
                         input logic [31:0] wx, input logic [31:0] wy, input logic [31:0] x,
                         input logic [31:0] y);
        mode = m; tag_in = tg; base_a = ba; dadx = dx; dady = dy;
        base_w = bw; dwdx = wx; dwdy = wy; px = x; py = y;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
    task automatic run_op(input string nm, input logic [1:0] m, input logic [7:0] tg,
                          input logic [127:0] ba, input logic [127:0] dx, input logic [127:0] dy,
                          input logic [31:0] bw, input logic [31:0] wx, input logic [31:0] wy,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [127:0] ea, input logic ee, input int lat);
        int cyc;
        exp_t e;
        drive(m, tg, ba, dx, dy, bw, wx, wy, x, y);
        e.attr = ea; e.tag = tg; e.err = ee;
        sbq.push_back(e);
        chk({nm, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, lat);
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, in_ready, 1);
    endtask

    logic [127:0] lin_ba, lin_dx, lin_dy;
    int           n_left;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'd0, 8'h00, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_attr", attr_out, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        lin_ba = {32'h0, 32'h0, 32'h00050000, 32'h00010000};
        lin_dx = {32'h0, 32'h0, 32'h0, 32'h00008000};
        lin_dy = {32'h0, 32'h0, 32'hFFFF0000, 32'h0};
        run_op("linear", 2'd1, 8'h11, lin_ba, lin_dx, lin_dy, 32'h00012345, 0, 0,
               32'h00040000, 32'h00030000, {32'h0, 32'h0, 32'h00020000, 32'h00030000}, 1'b0, 1);
        run_op("mode3", 2'd3, 8'h22, lin_ba, lin_dx, lin_dy, 32'h00012345, 0, 0,
               32'h00040000, 32'h00030000, {32'h0, 32'h0, 32'h00020000, 32'h00030000}, 1'b0, 1);
        run_op("flat", 2'd2, 8'h33, lin_ba, lin_dx, lin_dy, 32'h00012345, 0, 0,
               32'h00040000, 32'h00030000, lin_ba, 1'b0, 1);

        run_op("persp", 2'd0, 8'hA5, {4{32'h00020000}}, '0, '0, 32'h00008000, 0, 0, 0, 0,
               {4{32'h00040000}}, 1'b0, 37);
        run_op("persp_floor", 2'd0, 8'h5A,
               {32'h7FFF0000, 32'h00010000, 32'hFFFD0000, 32'h00030000}, '0, '0,
               32'h00010000, 32'h00010000, 0, 32'h00020000, 0,
               {32'h2AAA2AAB, 32'h00005555, 32'hFFFF0001, 32'h0000FFFF}, 1'b0, 37);
        run_op("div_zero", 2'd0, 8'h66,
               {32'h00008000, 32'hFFFF0000, 32'h0, 32'h00010000}, '0, '0, 32'h0, 0, 0, 0, 0,
               {32'h3FFFFFFF, 32'h80000001, 32'h0, 32'h7FFFFFFF}, 1'b1, 37);
        run_op("div_neg", 2'd0, 8'h67, {96'h0, 32'h00010000}, '0, '0, 32'hFFFF0000, 0, 0, 0, 0,
               {96'h0, 32'h7FFFFFFF}, 1'b1, 37);
        run_op("div_two", 2'd0, 8'h68, {96'h0, 32'h00010000}, '0, '0, 32'h00000002, 0, 0, 0, 0,
               {96'h0, 32'h7FFFFFFF}, 1'b1, 37);
        run_op("div_three", 2'd0, 8'h69, {64'h0, 32'h00020000, 32'h00010000}, '0, '0,
               32'h00000003, 0, 0, 0, 0,
               {64'h0, 32'h7FFFFFFF, 32'h55555555}, 1'b0, 37);

        run_op("sat_pos", 2'd1, 8'h70, {96'h0, 32'h7FFF0000}, {96'h0, 32'h00010000}, '0,
               0, 0, 0, 32'h00020000, 0, {96'h0, 32'h7FFFFFFF}, 1'b0, 1);
        run_op("sat_neg", 2'd1, 8'h71, {96'h0, 32'h80010000}, {96'h0, 32'h00010000}, '0,
               0, 0, 0, 32'hFFFE0000, 0, {96'h0, 32'h80000000}, 1'b0, 1);

        // Backpressure: result A held for 10 cycles while request B is offered.
        begin
            exp_t e;
            out_ready = 1'b0;
            drive(2'd1, 8'h77, {96'h0, 32'h00010000}, {96'h0, 32'h00008000}, '0,
                  0, 0, 0, 32'h00040000, 0);
            e.attr = {96'h0, 32'h00030000}; e.tag = 8'h77; e.err = 1'b0;
            sbq.push_back(e);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid_a", out_valid, 1);
            drive(2'd2, 8'h88, {32'h4, 32'h3, 32'h2, 32'h1}, '0, '0, 0, 0, 0, 0, 0);
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
                chk($sformatf("bp_hold_ready%0d", k), in_ready, 0);
                chk($sformatf("bp_hold_attr%0d", k), attr_out, {96'h0, 32'h00030000});
                chk($sformatf("bp_hold_tag%0d", k), tag_out, 8'h77);
            end
            e.attr = {32'h4, 32'h3, 32'h2, 32'h1}; e.tag = 8'h88; e.err = 1'b0;
            sbq.push_back(e);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_hs_valid", out_valid, 0);
            chk("bp_hs_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_accept_b", in_ready, 0);
            @(posedge clk); #1;
            chk("bp_valid_b", out_valid, 1);
            @(posedge clk); #1;
        end

        // Reset in the middle of the divide drops the request.
        drive(2'd0, 8'hEE, {4{32'h00020000}}, '0, '0, 32'h00008000, 0, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_attr", attr_out, 0);
        @(posedge clk); #1;
        run_op("persp_after_rst", 2'd0, 8'hA6, {4{32'h00020000}}, '0, '0, 32'h00008000,
               0, 0, 0, 0, {4{32'h00040000}}, 1'b0, 37);

        repeat (3) @(posedge clk);
        #1;
        n_left = sbq.size();
        chk("scoreboard_empty", n_left, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/persp_attr_interp_mc.md
PERSP_ATTR_INTERP_MC -- requirements
Module: persp_attr_interp_mc

Interface
REQ-001 SHALL have parameter W, default 32, signed fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 16, fractional bits (1 <= FRAC < W).
REQ-003 SHALL have parameter NCH, default 4, attribute channel count (>= 1).
REQ-004 SHALL have parameter TAGW, default 8, fragment tag width.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  request valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a request.
REQ-009 SHALL have port mode  input  2  0 perspective, 1 linear, 2 flat, 3 treated as linear.
REQ-010 SHALL have port tag_in  input  TAGW  fragment tag, returned unchanged.
REQ-011 SHALL have port base_a  input  NCH*W  per-channel A/w at origin, channel i in bits [i*W +: W].
REQ-012 SHALL have port dadx, dady  input  NCH*W each  per-channel A/w gradients, same packing.
REQ-013 SHALL have port base_w, dwdx, dwdy  input  W each  1/w plane coefficients.
REQ-014 SHALL have port px, py  input  W each  pixel coordinates, signed fixed-point.
REQ-015 SHALL have port out_valid  input-side pair out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port out_valid  output  1  result valid; attr_out  output  NCH*W  results; tag_out  output  TAGW; err  output  1  divide fault.

Function
REQ-017 SHALL accept a request on a rising edge with in_valid && in_ready, capturing all inputs; in_ready SHALL be 1 only in IDLE.
REQ-018 SHALL implement states IDLE, EVAL, DIV, MUL, DONE; IDLE->EVAL on accept.
REQ-019 EVAL (1 cycle) SHALL compute per channel num_i = sat((dadx_i*px + dady_i*py + (base_a_i<<<FRAC)) >>> FRAC) and den likewise from the 1/w plane, 2W-bit intermediate, arithmetic shift, saturation to [-2^(W-1), 2^(W-1)-1].
REQ-020 EVAL exit: mode 0 -> DIV; mode 1/3 -> DONE with attr_i = num_i; mode 2 -> DONE with attr_i = base_a_i.
REQ-021 DIV SHALL last exactly W cycles, computing recip = floor(2^(2*FRAC)/den) by one-bit-per-cycle restoring division, then -> MUL.
REQ-022 If den <= 0 or the quotient exceeds 2^(W-1)-1, recip SHALL be 2^(W-1)-1 and err SHALL be set; DIV timing unchanged.
REQ-023 MUL SHALL process one channel per cycle in index order 0..NCH-1: attr_i = sat((num_i*recip) >>> FRAC), then -> DONE.
REQ-024 Latency, accept edge = edge 0: out_valid SHALL be 1 after edge W+NCH+1 in mode 0 and after edge 1 in modes 1-3.
REQ-025 DONE SHALL hold out_valid=1 and attr_out, tag_out, err stable until out_valid && out_ready, then -> IDLE with out_valid=0.
REQ-026 in_valid SHALL be ignored in every state other than IDLE; no request overlap; next accept earliest the edge after the output handshake.
REQ-027 err SHALL be 0 for modes 1-3 and cleared on each new accept.
REQ-028 attr_out channels not yet written in MUL SHALL hold prior values; they are meaningful only while out_valid=1.

Reset
REQ-029 rst SHALL force state IDLE, in_ready=1, out_valid=0, attr_out=0, tag_out=0, err=0, divider registers 0, on the next edge, from any state.
REQ-030 rst mid-operation SHALL drop the in-flight request with no output handshake; rst has priority over in_valid and out_ready in the same cycle.

Verification (W=32, FRAC=16, NCH=4)
REQ-031 Linear: mode 1, base_a_0=0x00010000, dadx_0=0x00008000, dady_0=0, px=0x00040000 -> attr_0=0x00030000, out_valid after edge 1, err=0.
REQ-032 Perspective: mode 0, all base_a=0x00020000, base_w=0x00008000, gradients 0 -> recip=0x00020000, every attr=0x00040000, out_valid after exactly edge 37, tag_out=tag_in.
REQ-033 Divide fault: mode 0, base_w=0, base_a_0=0x00010000, base_a_1=0 -> err=1, attr_0=0x7FFFFFFF, attr_1=0, latency still 37.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no new accept; accept occurs only after the handshake.
REQ-035 Reset mid-DIV: rst at edge 10 of mode-0 op -> edge 11 shows IDLE, out_valid=0, in_ready=1; following REQ-032 request produces correct results.
REQ-036 Saturation: mode 1, base_a_0=0x7FFF0000, dadx_0=0x00010000, px=0x00020000 -> attr_0=0x7FFFFFFF; negative mirror -> 0x80000000.
